serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/serial_adder_if.sv | 18 +
 rtl/serial_adder_fa.sv | 11 +
 rtl/serial_adder.sv | 98 +++++++++
 tb/tb_serial_adder.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default operand width and FSM state codes.
package serial_adder_pkg;

  localparam int W_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int W = W_DEFAULT
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_fa.sv
// One-bit full adder used as the bit-slice of the serial datapath.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic su,
  output logic carry
);
  assign su    = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock through a single full adder, LSB first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_adder_if.slave bus
);
  localparam int             CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [W-1:0]  sr_q, sr_d;
  logic          c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          fa_su, fa_co;

  fa u_fa (
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .cin   (c_q),
    .su    (fa_su),
    .carry (fa_co)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          sr_d    = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        sr_d = {fa_su, sr_q[W-1:1]};
        c_d  = fa_co;
        if (cnt_q == CNT_LAST) begin
          // Result lands in the output registers only on entry to DONE.
          sum_d   = {fa_su, sr_q[W-1:1]};
          cout_d  = fa_co;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  serial_adder_if #(.W(W)) bus ();

  serial_adder #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci);
    ref_add = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  // One operation; rp >= 0 re-pulses start (a=0x11) at that RUN cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input int rp);
    logic [W:0]   exp;
    logic [W-1:0] s0;
    int bc, cyc, tog, extra;
    exp = ref_add(a, b, ci);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = ci;
    @(negedge clk);
    bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    bc = 0; cyc = 0; tog = 0; s0 = bus.sum;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) bc++;
      if (bus.sum !== s0) tog++;
      bus.start = (cyc == rp);
      if (cyc == rp) bus.a = 8'h11;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(bus.done), 32'd1);
    chk("busy_cycles", bc, W);
    chk("sum_quiet_in_run", tog, 0);
    chk("sum", 32'(bus.sum), 32'(exp[W-1:0]));
    chk("cout", 32'(bus.cout), 32'(exp[W]));
    chk("busy_in_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done_single", 32'(bus.done), 32'd0);
    chk("sum_hold", 32'(bus.sum), 32'(exp[W-1:0]));
    if (rp >= 0) begin
      extra = 0;
      for (int k = 0; k < 2 * W; k++) begin
        @(negedge clk);
        if (bus.done) extra++;
      end
      chk("no_extra_done", extra, 0);
    end
  endtask

  logic [W-1:0] opa [50];
  logic [W-1:0] opb [50];
  logic         opc [50];

  initial begin
    logic [W:0] r;
    int cyc, dn, nd;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h00, 8'h00, 1'b0, -1);
    run_op(8'hFF, 8'h01, 1'b0, -1);
    run_op(8'hA5, 8'h5A, 1'b1, -1);
    run_op(8'h3C, 8'h42, 1'b0, 3);
    for (int k = 0; k < 6; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), -1);
    run_op(8'h3C, 8'h42, 1'b0, -1);

    // Abort mid-RUN with an asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hF0; bus.b = 8'h0F; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("busy_before_abort", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_sum", 32'(bus.sum), 32'd0);
    chk("abort_cout", 32'(bus.cout), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 2 * W; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    chk("abort_quiet", dn, 0);
    run_op(8'h80, 8'h80, 1'b0, -1);

    // Start held high with fresh random operands every cycle.
    @(negedge clk);
    nd = 0;
    for (int i = 0; i < 52; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.done) begin
        chk("b2b_timing", i, 9 + (W + 2) * nd);
        cyc = i - (W + 1);
        if (cyc >= 0 && cyc < 40) begin
          r = ref_add(opa[cyc], opb[cyc], opc[cyc]);
          chk("b2b_sum", 32'(bus.sum), 32'(r[W-1:0]));
          chk("b2b_cout", 32'(bus.cout), 32'(r[W]));
        end
        nd++;
      end
      if (i < 40) begin
        opa[i] = W'($urandom); opb[i] = W'($urandom); opc[i] = 1'($urandom);
        bus.start = 1'b1; bus.a = opa[i]; bus.b = opb[i]; bus.cin = opc[i];
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("b2b_count", nd, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
